// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be: byte-enable simple dual-port RAM with clear-on-reset; ports clk, rst, wr/wr_add/wr_be/data_in (write), rd/rd_add (read request), data_out/rd_valid (read result), ready
module dual_port_ram_be #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 12,
  parameter int RD_LATENCY     = 1,
  parameter int COLLISION_MODE = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr,
  input  logic [ADDR_WIDTH-1:0]   wr_add,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd,
  input  logic [ADDR_WIDTH-1:0]   rd_add,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rd_valid,
  output logic                    ready
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mask, old_word, merged, rd_word, s_data;
  logic wr_go, rd_go, clr_go, s_valid;
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("RD_LATENCY must be 1 or 2");
  end
  for (genvar i = 0; i < BYTES; i++) begin : g_mask
    assign mask[8*i +: 8] = {8{wr_be[i]}};
  end
  assign ready    = state == RUN;
  assign wr_go    = ready & wr & ~rst;
  assign rd_go    = ready & rd & ~rst;
  assign clr_go   = state == CLEAR && CLEAR_ON_RESET != 0 && !rst;
  assign old_word = mem[rd_add];
  assign merged   = (old_word & ~mask) | (data_in & mask);
  assign rd_word  = (COLLISION_MODE != 0 && wr_go && wr_add == rd_add) ? merged : old_word;
  always_comb begin
    state_nxt = state;
    state_nxt = (state == CLEAR && (CLEAR_ON_RESET == 0 || cnt == '1)) ? RUN : state_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= clr_go ? cnt + 1'b1 : cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (clr_go) mem[cnt] <= '0;
    else if (wr_go) mem[wr_add] <= (mem[wr_add] & ~mask) | (data_in & mask);
  end
  if (RD_LATENCY == 1) begin : g_lat1
    assign s_valid = rd_go;
    assign s_data  = rd_word;
  end else begin : g_lat2
    logic p_valid;
    logic [DATA_WIDTH-1:0] p_data;
    always_ff @(posedge clk) begin
      p_valid <= rst ? 1'b0 : rd_go;
      if (rd_go) p_data <= rd_word;
    end
    assign s_valid = p_valid;
    assign s_data  = p_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= s_valid;
      if (s_valid) data_out <= s_data;
    end
  end
endmodule

// File: tb/tb_dual_port_ram_be.sv
// tb_dual_port_ram_be: two RAM configurations driven in lockstep and checked against a scoreboard model
module tb_dual_port_ram_be;
  localparam int AW = 4;
  localparam int DW = 64;
  localparam int BW = 8;
  localparam int DEPTH = 16;
  localparam int LAT [2] = '{1, 2};
  localparam int MODE [2] = '{0, 1};
  logic clk = 0, rst = 1, wr = 0, rd = 0;
  logic [AW-1:0] wr_add = '0, rd_add = '0;
  logic [BW-1:0] wr_be = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] dout0, dout1;
  logic vld0, vld1, rdy0, rdy1;
  logic [DW-1:0] dout [2];
  logic vld [2];
  logic rdy [2];
  int compared = 0, mismatched = 0, cyc = 0;
  logic [DW-1:0] m [2][DEPTH];
  logic [DW-1:0] ed [2][4];
  logic ev [2][4];
  logic [DW-1:0] last [2];
  int rel [2];
  assign dout[0] = dout0;
  assign dout[1] = dout1;
  assign vld[0] = vld0;
  assign vld[1] = vld1;
  assign rdy[0] = rdy0;
  assign rdy[1] = rdy1;
  always #5 clk = ~clk;
  dual_port_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .COLLISION_MODE(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst(rst), .wr(wr), .wr_add(wr_add), .wr_be(wr_be), .data_in(data_in),
    .rd(rd), .rd_add(rd_add), .data_out(dout0), .rd_valid(vld0), .ready(rdy0));
  dual_port_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2), .COLLISION_MODE(1), .CLEAR_ON_RESET(0)) u1 (
    .clk(clk), .rst(rst), .wr(wr), .wr_add(wr_add), .wr_be(wr_be), .data_in(data_in),
    .rd(rd), .rd_add(rd_add), .data_out(dout1), .rd_valid(vld1), .ready(rdy1));
  function automatic int need(int k);
    return k == 0 ? DEPTH : 1;
  endfunction
  function automatic logic [DW-1:0] merge(logic [DW-1:0] o, logic [DW-1:0] n, logic [BW-1:0] be);
    merge = o;
    for (int i = 0; i < BW; i++) if (be[i]) merge[8*i +: 8] = n[8*i +: 8];
  endfunction
  task automatic chk(string tag, int k, logic [DW-1:0] got, logic [DW-1:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s dut%0d cycle %0d: observed %h expected %h", tag, k, cyc, got, want);
    end
  endtask
  task automatic drive(logic w, logic [AW-1:0] wa, logic [BW-1:0] be, logic [DW-1:0] di, logic r, logic [AW-1:0] ra);
    wr = w;
    wr_add = wa;
    wr_be = be;
    data_in = di;
    rd = r;
    rd_add = ra;
  endtask
  task automatic tick();
    int due;
    logic [DW-1:0] nw;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        rel[k] = 0;
        last[k] = '0;
        for (int s = 0; s < 4; s++) ev[k][s] = 1'b0;
        if (k == 0) for (int a = 0; a < DEPTH; a++) m[k][a] = '0;
      end else begin
        if (rel[k] >= need(k)) begin
          nw = merge(m[k][wr_add], data_in, wr_be);
          if (rd) begin
            due = cyc + LAT[k] - 1;
            ed[k][due % 4] = (wr && wr_add == rd_add && MODE[k] == 1) ? nw : m[k][rd_add];
            ev[k][due % 4] = 1'b1;
          end
          if (wr) m[k][wr_add] = nw;
        end
        if (rel[k] < 1000) rel[k]++;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      if (ev[k][cyc % 4]) last[k] = ed[k][cyc % 4];
      chk("rd_valid", k, DW'(vld[k]), DW'(ev[k][cyc % 4]));
      ev[k][cyc % 4] = 1'b0;
      chk("data_out", k, dout[k], last[k]);
      chk("ready", k, DW'(rdy[k]), DW'(rel[k] >= need(k)));
    end
  endtask
  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
  endtask
  task automatic rand_ops(int n);
    for (int i = 0; i < n; i++) begin
      drive(1'($urandom), AW'($urandom & ((i % 2) ? 3 : 15)), (i % 5 == 0) ? '1 : BW'($urandom),
            {$urandom, $urandom}, 1'($urandom), AW'($urandom & ((i % 2) ? 3 : 15)));
      tick();
    end
  endtask
  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, '0, '0, '0, 1'b1, AW'(a));
      tick();
    end
    idle();
    tick();
    tick();
  endtask
  initial begin
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    repeat (DEPTH) tick();
    read_all();
    drive(1'b1, 4'h5, 8'hFF, 64'h1111_2222_3333_4444, 1'b0, '0);
    tick();
    drive(1'b1, 4'h5, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, '0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b1, 4'h5);
    tick();
    chk("be_merge", 0, dout[0], 64'h1111_2222_CCCC_DDDD);
    idle();
    tick();
    chk("be_merge", 1, dout[1], 64'h1111_2222_CCCC_DDDD);
    for (int a = 1; a <= 3; a++) begin
      drive(1'b0, '0, '0, '0, 1'b1, AW'(a));
      tick();
    end
    idle();
    tick();
    tick();
    drive(1'b1, 4'h7, 8'hFF, 64'h0, 1'b0, '0);
    tick();
    drive(1'b1, 4'h7, 8'h01, 64'hFFFF, 1'b1, 4'h7);
    tick();
    chk("collide", 0, dout[0], 64'h0);
    idle();
    tick();
    chk("collide", 1, dout[1], 64'h00FF);
    rand_ops(300);
    drive(1'b1, 4'h3, 8'hFF, 64'h55, 1'b0, '0);
    tick();
    idle();
    rst = 1;
    tick();
    rst = 0;
    tick();
    drive(1'b0, '0, '0, '0, 1'b1, 4'h3);
    tick();
    idle();
    tick();
    chk("no_clear", 1, dout[1], 64'h55);
    rand_ops(DEPTH);
    read_all();
    drive(1'b0, '0, '0, '0, 1'b1, 4'h9);
    tick();
    idle();
    rst = 1;
    tick();
    rst = 0;
    rand_ops(5);
    rst = 1;
    idle();
    tick();
    rst = 0;
    rand_ops(DEPTH);
    read_all();
    rand_ops(200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/dual_port_ram_be.md
# dual_port_ram_be

Parametrised simple dual-port RAM: one write port, one read port, one clock. It is the next generation of the fixed 64-bit × 4096 memory the team's dual-port RAM testbench targets. New features are:
- configurable width and depth;
- per-byte write enables;
- selectable read latency (1 or 2) with a read-valid strobe;
- defined read-during-write collision behaviour;
- a hardware clear-on-reset sequencer that zeroes every location before it accepts traffic.

## Interface

Parameters:
- DATA_WIDTH, 64, data width in bits; must be a multiple of 8 (elaboration error otherwise).
- ADDR_WIDTH, 12, address width; depth DEPTH = 2**ADDR_WIDTH.
- RD_LATENCY, 1, read latency in clock edges; legal values 1 or 2 (elaboration error otherwise).
- COLLISION_MODE, 0, behaviour for same-address read/write on the same edge: 0 = read-first (old data), 1 = write-first (new merged data).
- CLEAR_ON_RESET, 1, 1 = zero all locations after reset; 0 = skip clearing, contents retained.

Ports:
- clk, input, 1, single clock; all logic on posedge.
- rst, input, 1, synchronous, active-high reset.
- wr, input, 1, write request.
- wr_add, input, ADDR_WIDTH, write address.
- wr_be, input, DATA_WIDTH/8, byte enables; bit i covers data_in[8i+7:8i].
- data_in, input, DATA_WIDTH, write data.
- rd, input, 1, read request.
- rd_add, input, ADDR_WIDTH, read address.
- data_out, output, DATA_WIDTH, read data; holds its value between reads.
- rd_valid, output, 1, one-cycle strobe when data_out carries a new read result.
- ready, output, 1, high when the RAM accepts wr and rd.

## Operation

- Reset values: data_out = 0, rd_valid = 0, ready = 0. The read pipeline is cleared and the clear counter is set to 0.
- FSM states are CLEAR and RUN.
- Leaving reset with CLEAR_ON_RESET = 1 enters CLEAR.
  - Each edge writes all-zero to the counter address, then increments the counter.
  - After address DEPTH-1 is written, go to RUN and set ready = 1.
- Leaving reset with CLEAR_ON_RESET = 0 goes straight to RUN.
- In CLEAR, wr and rd are ignored, rd_valid stays 0, and data_out holds 0.
- Write (RUN): on an edge with wr = 1, every lane with wr_be[i] = 1 is updated from data_in; other lanes are unchanged. wr_be = 0 is a legal no-op.
- Read (RUN): on an edge with rd = 1, rd_add is captured and the result emerges per Timing. With rd = 0, data_out keeps its last value and rd_valid is 0.
- Collision (wr & rd, same address, same edge):
  - mode 0 returns the pre-write word;
  - mode 1 returns the byte-merged post-write word (new lanes where wr_be = 1, old lanes elsewhere).
- A write and a read to different addresses on the same edge are fully independent.
- Reset asserted mid-operation, including mid-CLEAR:
  - in-flight reads are discarded and never produce rd_valid;
  - outputs return to reset values;
  - CLEAR restarts from address 0.
- Addresses cover the full range 0..DEPTH-1; there is no out-of-range case.

## Timing

- Read latency:
  - RD_LATENCY = 1: read request sampled at edge N gives data_out/rd_valid updated at edge N, visible during cycle N+1.
  - RD_LATENCY = 2: results are updated at edge N+1.
- Throughput is one read and one write per cycle, sustained. Back-to-back reads give rd_valid high on consecutive cycles.
- A write at edge N is visible to a read sampled at edge N+1 or later, in either mode.
- Clear duration: with rst low at edges 1..DEPTH, edge k zeroes address k-1. ready rises at edge DEPTH and a read may be sampled at edge DEPTH+1. With CLEAR_ON_RESET = 0, ready rises at the first edge with rst low.
- rd_valid is a registered pulse: exactly one cycle per accepted read, never when rd was ignored.

## Test plan

- **Clear sequence.** DATA_WIDTH = 64, ADDR_WIDTH = 4, CLEAR_ON_RESET = 1: rst high 2 cycles, then low. Expect ready = 0 for 16 edges, then 1; reads of all 16 addresses return 0.
- **Byte-enable merge.** Write 64'h1111_2222_3333_4444 to 0x5 with wr_be = 8'hFF, then 64'hAAAA_BBBB_CCCC_DDDD with wr_be = 8'h0F. Read 0x5 returns 64'h1111_2222_CCCC_DDDD.
- **Latency and throughput.** RD_LATENCY = 2, reads of 0x1, 0x2, 0x3 on consecutive cycles. Expect rd_valid high exactly 3 consecutive cycles starting 2 edges after the first request, with data in request order.
- **Collision.** 0x7 holds 64'h0 and is written 64'hFFFF with wr_be = 8'h01 while read on the same edge. Mode 0 returns 64'h0; mode 1 returns 64'h00FF.
- **Reset mid-operation.** Issue a read at RD_LATENCY = 2, then assert rst on the next edge. Expect no rd_valid, data_out = 0, ready = 0, and CLEAR restarting from address 0.
- **No clear.** CLEAR_ON_RESET = 0: write 0x3 = 64'h55, pulse rst. Expect ready at the first edge after release and a read of 0x3 returning 64'h55.
